// File: rtl/fft_out_stream_if.sv
// fft_out_stream_if: frame-in / bin-out handshake bundle.
// master: load, din, out_ready. slave: the streamer.
interface fft_out_stream_if #(
  parameter int LEN = 8
) ();
  localparam int LW = $clog2(LEN);

  logic              load;
  logic [LEN*32-1:0] din;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_re;
  logic [15:0]       out_im;
  logic [LW-1:0]     out_idx;
  logic              out_last;
  logic              overrun;

  modport master (
    output load, din, out_ready,
    input  in_ready, out_valid, out_re,
    input  out_im, out_idx, out_last, overrun
  );

  modport slave (
    input  load, din, out_ready,
    output in_ready, out_valid, out_re,
    output out_im, out_idx, out_last, overrun
  );
endinterface

// File: rtl/fft_out_stream.sv
// fft_out_stream: latches one LEN-bin frame, streams one bin per beat.
// Ports: clk, rst_n (async low), bus (slave: load/din in, bin stream out).
module fft_out_stream #(
  parameter int LEN    = 8,
  parameter int BITREV = 0,
  parameter int SHIFT  = 0
) (
  input logic             clk,
  input logic             rst_n,
  fft_out_stream_if.slave bus
);
  localparam int LW = $clog2(LEN);
  localparam logic [LW-1:0] KLAST = LW'(LEN - 1);
  // Half an output LSB; zero when SHIFT is 0.
  localparam logic signed [16:0] RND =
    17'((2 ** SHIFT) >> 1);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e               state_q, state_d;
  logic [LW-1:0]        k_q, k_d;
  logic [LEN-1:0][31:0] buf_q, buf_d;
  logic                 ovr_q, ovr_d;

  logic          at_last;
  logic          hs;
  logic          in_rdy;
  logic          accept;
  logic [LW-1:0] lane;

  function automatic logic [LW-1:0] bitrev(
    input logic [LW-1:0] v
  );
    logic [LW-1:0] r;
    for (int i = 0; i < LW; i++)
      r[i] = v[LW-1-i];
    return r;
  endfunction

  function automatic logic [15:0] scale(
    input logic [15:0] x
  );
    logic signed [16:0] s;
    s = $signed({x[15], x}) + RND;
    s = s >>> SHIFT;
    return s[15:0];
  endfunction

  assign at_last = (k_q == KLAST);
  assign hs      = (state_q == STREAM) && bus.out_ready;
  // Last-beat handshake frees the buffer in the same cycle.
  assign in_rdy  = (state_q == IDLE) || (hs && at_last);
  assign accept  = bus.load && in_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      buf_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      buf_q   <= buf_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    buf_d   = buf_q;
    ovr_d   = ovr_q | (bus.load & ~in_rdy);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = STREAM;
          k_d     = '0;
          buf_d   = bus.din;
        end
      end
      STREAM: begin
        if (hs) begin
          if (!at_last) begin
            k_d = k_q + 1'b1;
          end else if (accept) begin
            k_d   = '0;
            buf_d = bus.din;
          end else begin
            state_d = IDLE;
            k_d     = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    lane          = (BITREV != 0) ? bitrev(k_q) : k_q;
    bus.in_ready  = in_rdy;
    bus.out_valid = (state_q == STREAM);
    bus.out_re    = scale(buf_q[lane][31:16]);
    bus.out_im    = scale(buf_q[lane][15:0]);
    bus.out_idx   = k_q;
    bus.out_last  = (state_q == STREAM) && at_last;
    bus.overrun   = ovr_q;
  end
endmodule

// File: tb/tb_fft_out_stream.sv
// tb_fft_out_stream: directed checks of fft_out_stream.
// Three instances: natural, bit-reversed, SHIFT=2.
module tb_fft_out_stream;
  localparam int LEN = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fft_out_stream_if #(.LEN(LEN)) nat_if ();
  fft_out_stream_if #(.LEN(LEN)) rev_if ();
  fft_out_stream_if #(.LEN(LEN)) shf_if ();

  fft_out_stream #(.LEN(LEN), .BITREV(0), .SHIFT(0)) u_nat (
    .clk(clk), .rst_n(rst_n), .bus(nat_if)
  );
  fft_out_stream #(.LEN(LEN), .BITREV(1), .SHIFT(0)) u_rev (
    .clk(clk), .rst_n(rst_n), .bus(rev_if)
  );
  fft_out_stream #(.LEN(LEN), .BITREV(0), .SHIFT(2)) u_shf (
    .clk(clk), .rst_n(rst_n), .bus(shf_if)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  logic [LEN*32-1:0] fa, fb, fs, fj;
  int rev_exp[8] = '{1, 5, 3, 7, 2, 6, 4, 8};
  int shf_re[8]  = '{5, -5, 6, -6, 32767, -32768, 2, -2};
  int shf_exp[8] = '{1, -1, 2, -1, 8192, -8192, 1, 0};
  bit pat[4]     = '{1'b1, 1'b0, 1'b0, 1'b1};
  logic [15:0] e16;
  int nxt;

  initial begin
    for (int j = 0; j < LEN; j++) begin
      fa[32*j +: 32] = {16'(j + 1), 16'(-(j + 1))};
      fb[32*j +: 32] = {16'(100 + j), 16'h0000};
      fs[32*j +: 32] = {16'(shf_re[j]), 16'h0000};
    end
    fj = '1;
    nat_if.load = 0; nat_if.din = '0; nat_if.out_ready = 0;
    rev_if.load = 0; rev_if.din = '0; rev_if.out_ready = 0;
    shf_if.load = 0; shf_if.din = '0; shf_if.out_ready = 0;

    #12;
    check("rst_valid", 32'(nat_if.out_valid), 0);
    check("rst_inrdy", 32'(nat_if.in_ready), 1);
    check("rst_re", 32'(nat_if.out_re), 0);
    check("rst_im", 32'(nat_if.out_im), 0);
    check("rst_idx", 32'(nat_if.out_idx), 0);
    check("rst_last", 32'(nat_if.out_last), 0);
    check("rst_ovr", 32'(nat_if.overrun), 0);
    check("rst_shf_re", 32'(shf_if.out_re), 0);
    rst_n = 1'b1;
    step();

    // natural order
    nat_if.din = fa; nat_if.load = 1; nat_if.out_ready = 1;
    step();
    nat_if.load = 0;
    for (int k = 0; k < LEN; k++) begin
      @(negedge clk);
      check("nat_valid", 32'(nat_if.out_valid), 1);
      check("nat_re", 32'(nat_if.out_re), 32'(k + 1));
      e16 = 16'(-(k + 1));
      check("nat_im", 32'(nat_if.out_im), 32'(e16));
      check("nat_idx", 32'(nat_if.out_idx), 32'(k));
      check("nat_last", 32'(nat_if.out_last), 32'(k == 7));
      check("nat_inrdy", 32'(nat_if.in_ready), 32'(k == 7));
      step();
    end
    @(negedge clk);
    check("nat_idle_valid", 32'(nat_if.out_valid), 0);
    check("nat_idle_inrdy", 32'(nat_if.in_ready), 1);
    step();

    // bit-reversed order
    rev_if.din = fa; rev_if.load = 1; rev_if.out_ready = 1;
    step();
    rev_if.load = 0;
    for (int k = 0; k < LEN; k++) begin
      @(negedge clk);
      check("rev_re", 32'(rev_if.out_re), 32'(rev_exp[k]));
      check("rev_idx", 32'(rev_if.out_idx), 32'(k));
      step();
    end

    // scaling
    shf_if.din = fs; shf_if.load = 1; shf_if.out_ready = 1;
    step();
    shf_if.load = 0;
    for (int k = 0; k < LEN; k++) begin
      @(negedge clk);
      e16 = 16'(shf_exp[k]);
      check("shf_re", 32'(shf_if.out_re), 32'(e16));
      check("shf_im", 32'(shf_if.out_im), 0);
      step();
    end

    // back-pressure
    nat_if.din = fa; nat_if.load = 1;
    step();
    nat_if.load = 0;
    nxt = 0;
    for (int c = 0; c < 64 && nxt < LEN; c++) begin
      nat_if.out_ready = pat[c % 4];
      @(negedge clk);
      check("bp_valid", 32'(nat_if.out_valid), 1);
      check("bp_re", 32'(nat_if.out_re), 32'(nxt + 1));
      check("bp_idx", 32'(nat_if.out_idx), 32'(nxt));
      if (nat_if.out_ready) nxt++;
      step();
    end
    check("bp_count", 32'(nxt), 8);
    @(negedge clk);
    check("bp_idle", 32'(nat_if.out_valid), 0);
    step();

    // back-to-back frames plus an ignored load at beat 3
    nat_if.out_ready = 1;
    nat_if.din = fa; nat_if.load = 1;
    step();
    for (int b = 0; b < 2 * LEN; b++) begin
      nat_if.load = (b == 3) || (b == 7);
      nat_if.din  = (b == 3) ? fj : (b == 7) ? fb : fa;
      @(negedge clk);
      check("b2b_valid", 32'(nat_if.out_valid), 1);
      check("b2b_re", 32'(nat_if.out_re),
            (b < 8) ? 32'(b + 1) : 32'(100 + b - 8));
      check("b2b_idx", 32'(nat_if.out_idx), 32'(b % 8));
      check("b2b_inrdy", 32'(nat_if.in_ready), 32'(b % 8 == 7));
      check("b2b_ovr", 32'(nat_if.overrun), 32'(b > 3));
      step();
    end
    nat_if.load = 0;
    @(negedge clk);
    check("b2b_end_valid", 32'(nat_if.out_valid), 0);
    check("b2b_end_ovr", 32'(nat_if.overrun), 1);
    step();

    // async reset mid-frame
    nat_if.din = fa; nat_if.load = 1;
    step();
    nat_if.load = 0;
    repeat (4) step();
    @(negedge clk);
    check("ar_pre_idx", 32'(nat_if.out_idx), 4);
    #2 rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(nat_if.out_valid), 0);
    check("ar_last", 32'(nat_if.out_last), 0);
    check("ar_ovr", 32'(nat_if.overrun), 0);
    check("ar_inrdy", 32'(nat_if.in_ready), 1);
    check("ar_idx", 32'(nat_if.out_idx), 0);
    check("ar_re", 32'(nat_if.out_re), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_hold_valid", 32'(nat_if.out_valid), 0);
    nat_if.load = 1;
    step();
    nat_if.load = 0;
    @(negedge clk);
    check("ar_new_valid", 32'(nat_if.out_valid), 1);
    check("ar_new_idx", 32'(nat_if.out_idx), 0);
    check("ar_new_re", 32'(nat_if.out_re), 1);
    step();
    @(negedge clk);
    check("ar_new_idx1", 32'(nat_if.out_idx), 1);
    check("ar_new_re1", 32'(nat_if.out_re), 2);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end
endmodule
